raptor64_bitfield: RTL and testbench

- Pipelined bit-field unit for the Raptor64 execute stage; the complement of the rotate/rotate-and-mask shifter.
- The shifter builds fields: ROLAM rotates left and masks.
- This block takes fields apart and rebuilds them:
  - extract, unsigned or signed, rotates right, masks and extends;
  - insert merges a rotated source into a destination word;
  - clear zeroes a field in a destination word.
- Two-stage valid/ready pipeline sitting beside the shifter. Results return with the destination-register tag.

---
 rtl/raptor64_bitfield_pkg.sv | 19 +
 rtl/raptor64_bf_mask.sv | 40 ++++
 rtl/raptor64_bitfield.sv | 158 +++++++++++++++
 tb/tb_raptor64_bitfield.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raptor64_bitfield_pkg.sv
// Shared definitions for the Raptor64 bit-field unit: opcode encodings and
// default widths.
package raptor64_bitfield_pkg;

  localparam int unsigned BF_WID_DEF  = 64;
  localparam int unsigned BF_TAGW_DEF = 5;

  typedef enum logic [1:0] {
    BF_EXTU = 2'b00,
    BF_EXT  = 2'b01,
    BF_INS  = 2'b10,
    BF_CLR  = 2'b11
  } bf_op_e;

  function automatic logic bf_is_extract(input bf_op_e op);
    return (op == BF_EXTU) || (op == BF_EXT);
  endfunction

endpackage

// File: rtl/raptor64_bf_mask.sv
// Field geometry for the bit-field unit: (mb, me) -> field width, low-aligned
// mask and in-place mask. Purely combinational.
module raptor64_bf_mask
  import raptor64_bitfield_pkg::*;
#(
  parameter  int unsigned WID = BF_WID_DEF,
  localparam int unsigned IW  = $clog2(WID)
) (
  input  logic [IW-1:0]  mb_i,
  input  logic [IW-1:0]  me_i,
  output logic [IW:0]    w_o,
  output logic [WID-1:0] lowmask_o,
  output logic [WID-1:0] fmask_o
);

  logic [IW-1:0] w_span;

  function automatic logic [WID-1:0] rotl(input logic [WID-1:0] x, input logic [IW-1:0] s);
    logic [IW:0] inv;
    inv = (IW+1)'(WID) - {1'b0, s};
    return (x << s) | (x >> inv);
  endfunction

  // Width is (me - mb) mod WID plus one, so mb > me wraps around bit WID-1.
  assign w_span = me_i - mb_i;
  assign w_o    = {1'b0, w_span} + {{IW{1'b0}}, 1'b1};

  // Low-aligned mask of w ones; a full-width field cannot be made by shifting.
  always_comb begin
    lowmask_o = {WID{1'b0}};
    if (w_o[IW]) begin
      lowmask_o = {WID{1'b1}};
    end else begin
      lowmask_o = ({{(WID-1){1'b0}}, 1'b1} << w_o[IW-1:0]) - {{(WID-1){1'b0}}, 1'b1};
    end
  end

  assign fmask_o = rotl(lowmask_o, mb_i);

endmodule

// File: rtl/raptor64_bitfield.sv
// Raptor64 two-stage bit-field unit: extract (unsigned/signed), insert and
// clear, with a valid/ready pipeline carrying the destination tag.
module raptor64_bitfield
  import raptor64_bitfield_pkg::*;
#(
  parameter  int unsigned WID  = BF_WID_DEF,
  parameter  int unsigned TAGW = BF_TAGW_DEF,
  localparam int unsigned IW   = $clog2(WID)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [WID-1:0]  a_i,
  input  logic [WID-1:0]  b_i,
  input  logic [IW-1:0]   mb_i,
  input  logic [IW-1:0]   me_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [WID-1:0]  res_o,
  output logic [TAGW-1:0] tag_o,
  output logic            busy_o
);

  logic            w_accept;
  logic            w_s2_load;
  logic            w_ready;
  bf_op_e          w_op;
  logic [IW:0]     w_w;
  logic [WID-1:0]  w_lowmask;
  logic [WID-1:0]  w_fmask;
  logic [WID-1:0]  w_rot;
  logic [WID-1:0]  w_res;
  logic            w_sign;

  logic            r_s1_valid;
  bf_op_e          r_s1_op;
  logic [TAGW-1:0] r_s1_tag;
  logic [WID-1:0]  r_s1_rot;
  logic [WID-1:0]  r_s1_b;
  logic [WID-1:0]  r_s1_lowmask;
  logic [WID-1:0]  r_s1_fmask;
  logic [IW-1:0]   r_s1_sidx;
  logic            r_s1_full;

  logic            r_valid_o;
  logic [WID-1:0]  r_res;
  logic [TAGW-1:0] r_tag;

  function automatic logic [WID-1:0] rotl(input logic [WID-1:0] x, input logic [IW-1:0] s);
    logic [IW:0] inv;
    inv = (IW+1)'(WID) - {1'b0, s};
    return (x << s) | (x >> inv);
  endfunction

  function automatic logic [WID-1:0] rotr(input logic [WID-1:0] x, input logic [IW-1:0] s);
    logic [IW:0] inv;
    inv = (IW+1)'(WID) - {1'b0, s};
    return (x >> s) | (x << inv);
  endfunction

  raptor64_bf_mask #(.WID(WID)) u_mask (
    .mb_i      (mb_i),
    .me_i      (me_i),
    .w_o       (w_w),
    .lowmask_o (w_lowmask),
    .fmask_o   (w_fmask)
  );

  assign w_op      = bf_op_e'(op_i);
  assign w_s2_load = r_s1_valid && (!r_valid_o || ready_i);
  assign w_ready   = !r_s1_valid || w_s2_load;
  assign w_accept  = valid_i && w_ready;

  // Extracts bring the field down to bit 0; inserts move the source up to mb.
  always_comb begin
    w_rot = {WID{1'b0}};
    if (bf_is_extract(w_op)) begin
      w_rot = rotr(a_i, mb_i);
    end else begin
      w_rot = rotl(a_i, mb_i);
    end
  end

  // Stage 1: capture the operation and its precomputed masks on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid   <= 1'b0;
      r_s1_op      <= BF_EXTU;
      r_s1_tag     <= {TAGW{1'b0}};
      r_s1_rot     <= {WID{1'b0}};
      r_s1_b       <= {WID{1'b0}};
      r_s1_lowmask <= {WID{1'b0}};
      r_s1_fmask   <= {WID{1'b0}};
      r_s1_sidx    <= {IW{1'b0}};
      r_s1_full    <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid   <= 1'b1;
      r_s1_op      <= w_op;
      r_s1_tag     <= tag_i;
      r_s1_rot     <= w_rot;
      r_s1_b       <= b_i;
      r_s1_lowmask <= w_lowmask;
      r_s1_fmask   <= w_fmask;
      r_s1_sidx    <= w_w[IW-1:0] - {{(IW-1){1'b0}}, 1'b1};
      r_s1_full    <= w_w[IW];
    end else if (w_s2_load) begin
      r_s1_valid   <= 1'b0;
    end else begin
      r_s1_valid   <= r_s1_valid;
    end
  end

  // Stage 2 datapath: select, sign-extend from bit w-1, or merge into b.
  always_comb begin
    w_sign = r_s1_rot[r_s1_sidx];
    w_res  = {WID{1'b0}};
    case (r_s1_op)
      BF_EXTU: w_res = r_s1_rot & r_s1_lowmask;
      BF_EXT: begin
        if (w_sign && !r_s1_full) begin
          w_res = r_s1_rot | ~r_s1_lowmask;
        end else begin
          w_res = r_s1_rot & r_s1_lowmask;
        end
      end
      BF_INS:  w_res = (r_s1_b & ~r_s1_fmask) | (r_s1_rot & r_s1_fmask);
      BF_CLR:  w_res = r_s1_b & ~r_s1_fmask;
      default: w_res = {WID{1'b0}};
    endcase
  end

  // Stage 2 output register; holds its result while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_res     <= {WID{1'b0}};
      r_tag     <= {TAGW{1'b0}};
    end else if (w_s2_load) begin
      r_valid_o <= 1'b1;
      r_res     <= w_res;
      r_tag     <= r_s1_tag;
    end else if (ready_i) begin
      r_valid_o <= 1'b0;
    end else begin
      r_valid_o <= r_valid_o;
    end
  end

  assign ready_o = w_ready;
  assign valid_o = r_valid_o;
  assign res_o   = r_res;
  assign tag_o   = r_tag;
  assign busy_o  = r_s1_valid || r_valid_o;

endmodule

// File: tb/tb_raptor64_bitfield.sv
// Self-checking bench for raptor64_bitfield: directed field cases, back-pressure,
// mid-stream reset and a randomised stream checked through a scoreboard.
module tb_raptor64_bitfield;
  import raptor64_bitfield_pkg::*;

  localparam int WID  = 64;
  localparam int TAGW = 5;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      op_i;
  logic [WID-1:0]  a_i;
  logic [WID-1:0]  b_i;
  logic [5:0]      mb_i;
  logic [5:0]      me_i;
  logic [TAGW-1:0] tag_i;
  logic            valid_o;
  logic            ready_i;
  logic [WID-1:0]  res_o;
  logic [TAGW-1:0] tag_o;
  logic            busy_o;

  int n_vec = 0;
  int n_err = 0;
  logic [WID+TAGW-1:0] sb_q[$];
  bit rnd_done;

  logic            hold_v = 1'b0;
  logic [WID-1:0]  hold_res;
  logic [TAGW-1:0] hold_tag;

  raptor64_bitfield #(.WID(WID), .TAGW(TAGW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .mb_i    (mb_i),
    .me_i    (me_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o),
    .tag_o   (tag_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask

  // Bit-by-bit reference, written independently of the RTL mask/rotate scheme.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic [5:0] mb,
                                            input logic [5:0] me);
    int w;
    logic [63:0] r;
    w = ((int'(me) - int'(mb)) & 63) + 1;
    if (op == BF_EXTU || op == BF_EXT) begin
      r = 64'd0;
      for (int i = 0; i < w; i++) r[i] = a[(int'(mb) + i) % 64];
      if (op == BF_EXT)
        for (int i = w; i < 64; i++) r[i] = r[w-1];
    end else begin
      r = b;
      for (int i = 0; i < w; i++)
        r[(int'(mb) + i) % 64] = (op == BF_INS) ? a[i] : 1'b0;
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [5:0] mb, input logic [5:0] me, input logic [4:0] tg,
                      input logic [63:0] exp);
    int n;
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; mb_i = mb; me_i = me; tag_i = tg;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
      if (n > 60) break;
    end
    if (ready_o) sb_q.push_back({exp, tg});
    else chk_eq("accept_timeout", 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_m(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] mb, input logic [5:0] me, input logic [4:0] tg);
    send(op, a, b, mb, me, tg, ref_model(op, a, b, mb, me));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk_eq("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard pops on transfer, stability check while stalled.
  always @(negedge clk_i) begin
    logic [WID+TAGW-1:0] e;
    if (!rst_ni) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk_eq("hold_res", res_o, hold_res);
        chk_eq("hold_tag", 64'(tag_o), 64'(hold_tag));
      end
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          chk_eq("unexpected_valid", 64'(valid_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk_eq("res", res_o, e[WID+TAGW-1:TAGW]);
          chk_eq("tag", 64'(tag_o), 64'(e[TAGW-1:0]));
        end
      end
      hold_v   = valid_o && !ready_i;
      hold_res = res_o;
      hold_tag = tag_o;
    end
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op_i = 2'b00;
    a_i = 64'd0; b_i = 64'd0; mb_i = 6'd0; me_i = 6'd0; tag_i = 5'd0;
    #12;
    chk_eq("rst_valid_o", 64'(valid_o), 64'd0);
    chk_eq("rst_busy_o", 64'(busy_o), 64'd0);
    chk_eq("rst_res_o", res_o, 64'd0);
    chk_eq("rst_tag_o", 64'(tag_o), 64'd0);
    #10;
    rst_ni = 1'b1;
    #1;
    chk_eq("rst_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;

    // Directed cases with latency check on the first one.
    send(BF_EXTU, 64'h0000_0000_0000_ABC0, 64'd0, 6'd4, 6'd15, 5'd3, 64'h0000_0000_0000_0ABC);
    chk_eq("lat_cycle1", 64'(valid_o), 64'd0);
    @(posedge clk_i); #1;
    chk_eq("lat_cycle2", 64'(valid_o), 64'd1);
    send(BF_EXT,  64'h0000_0000_0000_8000, 64'd0, 6'd12, 6'd15, 5'd4, 64'hFFFF_FFFF_FFFF_FFF8);
    send(BF_EXTU, 64'h0000_0000_0000_8000, 64'd0, 6'd12, 6'd15, 5'd5, 64'h0000_0000_0000_0008);
    send(BF_INS,  64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 6'd62, 6'd1, 5'd6, 64'h7FFF_FFFF_FFFF_FFFD);
    send(BF_CLR,  64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 6'd62, 6'd1, 5'd7, 64'h3FFF_FFFF_FFFF_FFFC);
    send(BF_EXT,  64'h8123_4567_89AB_CDEF, 64'd0, 6'd0, 6'd63, 5'd8, 64'h8123_4567_89AB_CDEF);
    send(BF_EXT,  64'h8000_0000_0000_0000, 64'd0, 6'd63, 6'd63, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    send(BF_EXTU, 64'h8000_0000_0000_0000, 64'd0, 6'd63, 6'd63, 5'd10, 64'h0000_0000_0000_0001);
    drain();
    chk_eq("idle_busy", 64'(busy_o), 64'd0);

    // Back-pressure: 4 back-to-back ops with the consumer stalled for 5 cycles.
    fork
      begin
        send_m(BF_EXTU, 64'hDEAD_BEEF_0123_4567, 64'd0, 6'd8, 6'd23, 5'd1);
        send_m(BF_INS,  64'h0000_0000_0000_00A5, 64'h1111_2222_3333_4444, 6'd60, 6'd3, 5'd2);
        send_m(BF_EXT,  64'h0000_0000_00F0_0000, 64'd0, 6'd20, 6'd23, 5'd3);
        send_m(BF_CLR,  64'd0, 64'hFFFF_0000_FFFF_0000, 6'd40, 6'd7, 5'd4);
      end
      begin
        ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_eq("bp_ready_low", 64'(ready_o), 64'd0);
        chk_eq("bp_busy", 64'(busy_o), 64'd1);
        repeat (2) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_i);
          chk_eq("bp_no_gap", 64'(valid_o), 64'd1);
        end
      end
    join
    drain();

    // Reset with two operations in flight.
    ready_i = 1'b0;
    send(BF_EXTU, 64'h0000_0000_0000_ABC0, 64'd0, 6'd4, 6'd15, 5'd17, 64'h0000_0000_0000_0ABC);
    send(BF_EXTU, 64'h0000_0000_0000_1230, 64'd0, 6'd4, 6'd15, 5'd18, 64'h0000_0000_0000_0123);
    rst_ni = 1'b0;
    #1;
    chk_eq("mrst_valid_o", 64'(valid_o), 64'd0);
    chk_eq("mrst_busy_o", 64'(busy_o), 64'd0);
    chk_eq("mrst_res_o", res_o, 64'd0);
    chk_eq("mrst_tag_o", 64'(tag_o), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    #1;
    chk_eq("mrst_ready_o", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk_eq("mrst_no_stale", 64'(valid_o), 64'd0);
    end
    @(posedge clk_i); #1;
    send(BF_INS, 64'h3, 64'd0, 6'd10, 6'd11, 5'd21, 64'h0000_0000_0000_0C00);
    drain();

    // Random stream with random consumer back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          send_m(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 5'(k));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_i); #1;
          ready_i = 1'($urandom_range(0, 1));
        end
        ready_i = 1'b1;
      end
    join
    drain();
    chk_eq("final_busy", 64'(busy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
